// File: rtl/ddp_pkg.sv
// Shared constants and types for the DDP receive-buffer registration pool.
package ddp_pkg;

  localparam int unsigned DDP_POOL_DEPTH = 32;
  localparam int unsigned DDP_PTR_W      = 5;
  localparam int unsigned DDP_SLOT_BYTES = 4096;
  localparam int unsigned DDP_ADDR_W     = 64;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pool_state_e;

endpackage

// File: rtl/ddp_slot_ram.sv
// Slot address table: one write port, one registered read port (read-before-write).
module ddp_slot_ram #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned IDX_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] rdata_q;

  // Table storage; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read; a same-cycle write to the same slot is not visible yet.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ddp_buf_pool.sv
// Receive-buffer registration pool: circular slot table filled by registration,
// released oldest-first by the transmit path.
module ddp_buf_pool
  import ddp_pkg::*;
#(
  parameter int unsigned DEPTH      = DDP_POOL_DEPTH,
  parameter int unsigned SLOT_BYTES = DDP_SLOT_BYTES,
  parameter int unsigned ADDR_W     = DDP_ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bufRegister,
  input  logic [2:0]           rgstrNum,
  input  logic [ADDR_W-1:0]    rgstrAddr,
  output logic                 rgstrBusy,
  output logic                 rgstrAck,
  output logic                 rgstrReject,
  output logic [DDP_PTR_W-1:0] rgstrPtr,
  output logic [DDP_PTR_W-1:0] lastNum,
  output logic                 poolEmpty,
  output logic                 poolFull,
  output logic [DDP_PTR_W:0]   freeCount,
  input  logic                 bufRelease,
  input  logic [2:0]           releaseNum,
  output logic                 releaseErr,
  input  logic [DDP_PTR_W-1:0] slotRdAddr,
  output logic [ADDR_W-1:0]    slotRdData
);

  localparam logic [DDP_PTR_W:0] DEPTH_CNT = (DDP_PTR_W+1)'(DEPTH);

  pool_state_e           state_q;
  logic                  busy_q, ack_q, reject_q, rel_err_q;
  logic [DDP_PTR_W-1:0]  wr_ptr_q, rd_ptr_q, last_q, fill_idx_q;
  logic [2:0]            n_q, k_q;
  logic [ADDR_W-1:0]     acc_q;
  logic [DDP_PTR_W:0]    used_q, used_d, free_q;
  logic                  empty_q, full_q;

  logic                  accept, fill_last, rel_over;
  logic [DDP_PTR_W:0]    req_n, rel_n, rel_m, reserve;

  // Admission, release clamp and next used count (release clamps on pre-reservation used).
  always_comb begin
    req_n     = {3'b000, rgstrNum};
    rel_n     = {3'b000, releaseNum};
    accept    = (state_q == IDLE) && bufRegister && (rgstrNum != 3'd0) && (req_n <= free_q);
    reserve   = accept ? req_n : '0;
    rel_over  = bufRelease && (rel_n > used_q);
    rel_m     = '0;
    if (bufRelease) rel_m = rel_over ? used_q : rel_n;
    used_d    = used_q + reserve - rel_m;
    fill_last = (state_q == FILL) && (k_q == n_q - 3'd1);
  end

  // Registration FSM: reserve on accept, then write one slot per FILL cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      reject_q   <= 1'b0;
      wr_ptr_q   <= '0;
      last_q     <= '0;
      fill_idx_q <= '0;
      n_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
    end else begin
      ack_q    <= 1'b0;
      reject_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bufRegister) begin
            if (accept) begin
              n_q        <= rgstrNum;
              acc_q      <= rgstrAddr;
              fill_idx_q <= wr_ptr_q;
              k_q        <= '0;
              busy_q     <= 1'b1;
              state_q    <= FILL;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        FILL: begin
          fill_idx_q <= fill_idx_q + 1'b1;
          k_q        <= k_q + 3'd1;
          acc_q      <= acc_q + ADDR_W'(SLOT_BYTES);
          if (fill_last) begin
            wr_ptr_q <= fill_idx_q + 1'b1;
            last_q   <= fill_idx_q;
            ack_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Occupancy, read pointer and registered status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      used_q    <= '0;
      rd_ptr_q  <= '0;
      rel_err_q <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      free_q    <= DEPTH_CNT;
    end else begin
      used_q    <= used_d;
      rd_ptr_q  <= rd_ptr_q + rel_m[DDP_PTR_W-1:0];
      rel_err_q <= rel_over;
      empty_q   <= (used_d == '0);
      full_q    <= (used_d == DEPTH_CNT);
      free_q    <= DEPTH_CNT - used_d;
    end
  end

  ddp_slot_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IDX_W  (DDP_PTR_W)
  ) u_slot_ram (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (state_q == FILL),
    .waddr_i (fill_idx_q),
    .wdata_i (acc_q),
    .raddr_i (slotRdAddr),
    .rdata_o (slotRdData)
  );

  assign rgstrBusy   = busy_q;
  assign rgstrAck    = ack_q;
  assign rgstrReject = reject_q;
  assign rgstrPtr    = wr_ptr_q;
  assign lastNum     = last_q;
  assign poolEmpty   = empty_q;
  assign poolFull    = full_q;
  assign freeCount   = free_q;
  assign releaseErr  = rel_err_q;

endmodule

// File: tb/tb_ddp_buf_pool.sv
// Randomized bench for ddp_buf_pool against a transaction-level pool model.
module tb_ddp_buf_pool;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bufRegister = 1'b0;
  logic [2:0]  rgstrNum = '0;
  logic [63:0] rgstrAddr = '0;
  logic        rgstrBusy, rgstrAck, rgstrReject;
  logic [4:0]  rgstrPtr, lastNum;
  logic        poolEmpty, poolFull;
  logic [5:0]  freeCount;
  logic        bufRelease = 1'b0;
  logic [2:0]  releaseNum = '0;
  logic        releaseErr;
  logic [4:0]  slotRdAddr = '0;
  logic [63:0] slotRdData;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: occupancy, allocation pointer, last slot, and table image.
  int          m_used, m_wr, m_last;
  logic [63:0] m_tbl [32];
  bit          m_known [32];

  ddp_buf_pool #(.DEPTH(32), .SLOT_BYTES(4096), .ADDR_W(64)) dut (
    .clock(clock), .reset(reset),
    .bufRegister(bufRegister), .rgstrNum(rgstrNum), .rgstrAddr(rgstrAddr),
    .rgstrBusy(rgstrBusy), .rgstrAck(rgstrAck), .rgstrReject(rgstrReject),
    .rgstrPtr(rgstrPtr), .lastNum(lastNum),
    .poolEmpty(poolEmpty), .poolFull(poolFull), .freeCount(freeCount),
    .bufRelease(bufRelease), .releaseNum(releaseNum), .releaseErr(releaseErr),
    .slotRdAddr(slotRdAddr), .slotRdData(slotRdData)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_used = 0; m_wr = 0; m_last = 0;
    for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
  endtask

  task automatic chk_status();
    chk("freeCount", freeCount, 64'(32 - m_used));
    chk("poolEmpty", poolEmpty, m_used == 0);
    chk("poolFull",  poolFull,  m_used == 32);
  endtask

  task automatic do_register(input int n, input logic [63:0] addr, input bit rel, input int rnum);
    bit acc, err;
    int m, cnt;
    @(negedge clock);
    bufRegister = 1'b1; rgstrNum = 3'(n); rgstrAddr = addr;
    bufRelease = rel;   releaseNum = 3'(rnum);
    acc = (n != 0) && (n <= 32 - m_used);
    m   = rel ? ((rnum < m_used) ? rnum : m_used) : 0;
    err = rel && (rnum > m_used);
    @(negedge clock);
    bufRegister = 1'b0; bufRelease = 1'b0;
    m_used = m_used + (acc ? n : 0) - m;
    chk("rgstrReject", rgstrReject, !acc);
    chk("releaseErr", releaseErr, err);
    chk_status();
    if (acc) begin
      cnt = 0;
      while (rgstrBusy === 1'b1 && cnt < 16) begin
        chk("ptr_hold", rgstrPtr, 64'(m_wr));
        cnt++;
        @(negedge clock);
      end
      chk("busy_cycles", 64'(cnt), 64'(n));
      chk("rgstrAck", rgstrAck, 1'b1);
      for (int i = 0; i < n; i++) begin
        m_tbl[(m_wr + i) % 32]   = addr + 64'(i) * 64'd4096;
        m_known[(m_wr + i) % 32] = 1'b1;
      end
      m_last = (m_wr + n - 1) % 32;
      m_wr   = (m_wr + n) % 32;
      chk("rgstrPtr", rgstrPtr, 64'(m_wr));
      chk("lastNum", lastNum, 64'(m_last));
      @(negedge clock);
      chk("ack_pulse", rgstrAck, 1'b0);
    end else begin
      chk("busy_idle", rgstrBusy, 1'b0);
      chk("rgstrPtr_rej", rgstrPtr, 64'(m_wr));
      chk("lastNum_rej", lastNum, 64'(m_last));
      @(negedge clock);
      chk("rej_pulse", rgstrReject, 1'b0);
    end
  endtask

  task automatic do_release(input int rnum);
    bit err;
    int m;
    @(negedge clock);
    bufRelease = 1'b1; releaseNum = 3'(rnum);
    m   = (rnum < m_used) ? rnum : m_used;
    err = rnum > m_used;
    @(negedge clock);
    bufRelease = 1'b0;
    m_used = m_used - m;
    chk("releaseErr", releaseErr, err);
    chk_status();
  endtask

  task automatic check_table();
    for (int i = 0; i < 32; i++) begin
      if (m_known[i]) begin
        @(negedge clock);
        slotRdAddr = 5'(i);
        @(negedge clock);
        chk($sformatf("table[%0d]", i), slotRdData, m_tbl[i]);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [63:0] a;
    int op;
    model_clear();
    repeat (2) @(negedge clock);
    chk("rst_busy", rgstrBusy, 1'b0);
    chk("rst_ack", rgstrAck, 1'b0);
    chk("rst_rej", rgstrReject, 1'b0);
    chk("rst_relerr", releaseErr, 1'b0);
    chk("rst_ptr", rgstrPtr, 5'd0);
    chk("rst_last", lastNum, 5'd0);
    chk("rst_rddata", slotRdData, 64'd0);
    chk_status();
    reset = 1'b0;

    // First registration: 3 slots from 0x1000.
    do_register(3, 64'h1000, 1'b0, 0);
    check_table();

    // Fill to full, wrap to 0, then a refused request.
    pulse_reset();
    do_register(7, 64'h10_0000, 1'b0, 0);
    do_register(7, 64'h20_0000, 1'b0, 0);
    do_register(7, 64'h30_0000, 1'b0, 0);
    do_register(7, 64'h40_0000, 1'b0, 0);
    do_register(4, 64'h50_0000, 1'b0, 0);
    do_register(1, 64'h60_0000, 1'b0, 0);
    do_register(0, 64'h70_0000, 1'b0, 0);
    check_table();

    // used=30, register 2 while releasing 2 in the same cycle.
    do_release(2);
    do_register(2, 64'h80_0000, 1'b1, 2);

    // Wrap-around fill from slot 30 with an empty pool.
    pulse_reset();
    do_register(7, 64'h1_0000, 1'b0, 0);
    do_register(7, 64'h2_0000, 1'b0, 0);
    do_register(7, 64'h3_0000, 1'b0, 0);
    do_register(7, 64'h4_0000, 1'b0, 0);
    do_register(2, 64'h5_0000, 1'b0, 0);
    for (int i = 0; i < 4; i++) do_release(7);
    do_release(2);
    do_register(4, 64'hFFFF_FFFF_FFFF_E000, 1'b0, 0);
    check_table();

    // Over-release with used=5.
    do_register(1, 64'h9000, 1'b0, 0);
    do_release(7);
    do_release(0);

    // Reset two cycles into a 5-slot fill.
    @(negedge clock);
    bufRegister = 1'b1; rgstrNum = 3'd5; rgstrAddr = 64'hA000;
    @(negedge clock);
    bufRegister = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    chk("midrst_busy", rgstrBusy, 1'b0);
    chk("midrst_ack", rgstrAck, 1'b0);
    chk("midrst_ptr", rgstrPtr, 5'd0);
    chk_status();
    @(negedge clock);
    chk("midrst_noack", rgstrAck, 1'b0);
    do_register(1, 64'hB000, 1'b0, 0);

    // Randomized mix of registration, release and both together.
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 2);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) a = 64'hFFFF_FFFF_FFFF_C000;
      case (op)
        0:       do_register($urandom_range(0, 7), a, 1'b0, 0);
        1:       do_release($urandom_range(0, 7));
        default: do_register($urandom_range(0, 7), a, 1'b1, $urandom_range(0, 7));
      endcase
      if (it % 50 == 49) check_table();
    end
    check_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/ddp_buf_pool.md
Name: ddp_buf_pool

Overview:
Receive-buffer registration pool that sits directly downstream of the RDMAP header generator.
- Consumes its registration request (bufRegister, rgstrNum, plus host base address rgstrAddr).
- Returns pool status to it: rgstrPtr, lastNum, poolEmpty, poolFull.
- Holds a circular table of host buffer slot addresses. Registration fills it; the DDP transmit path releases it in FIFO order and reads it by index.

Parameters:
DEPTH, 32, number of slots; power of two, pointer width fixed at 5 by the port widths.
SLOT_BYTES, 4096, host address stride between consecutive slots of one registration.
ADDR_W, 64, host address width.

Ports:
clock  in  1  single clock.
reset  in  1  asynchronous, active-high reset.
bufRegister  in  1  registration request; sampled only in IDLE.
rgstrNum  in  3  slots requested (1..7).
rgstrAddr  in  ADDR_W  host address of the first slot.
rgstrBusy  out  1  high while FILL is in progress.
rgstrAck  out  1  1-cycle pulse when a registration completes.
rgstrReject  out  1  1-cycle pulse when a request is refused.
rgstrPtr  out  5  write pointer: index of the next slot to allocate.
lastNum  out  5  index of the last slot of the most recent completed registration.
poolEmpty  out  1  used count == 0.
poolFull  out  1  used count == DEPTH.
freeCount  out  6  DEPTH minus used count.
bufRelease  in  1  release request.
releaseNum  in  3  slots to release, oldest first.
releaseErr  out  1  1-cycle pulse when a release is over-requested.
slotRdAddr  in  5  table read index.
slotRdData  out  ADDR_W  table read data, registered, 1-cycle latency.

Behaviour:
- Reset (async, active-high):
  - wrPtr, rdPtr, used, lastNum, slotRdData = 0.
  - rgstrBusy, rgstrAck, rgstrReject, releaseErr = 0.
  - poolEmpty = 1, poolFull = 0, freeCount = 32.
  - State = IDLE. Table contents are don't-care.
- State machine: IDLE, FILL.
- IDLE, bufRegister = 1:
  - If rgstrNum == 0 or rgstrNum > freeCount (the registered value, before this cycle's release): pulse rgstrReject next cycle and stay in IDLE.
  - Otherwise: latch n = rgstrNum, base = rgstrAddr, fillIdx = wrPtr, k = 0. Increase used by n in the same edge (reserve), go to FILL, assert rgstrBusy.
- FILL, one slot per cycle:
  - table[fillIdx] <= base + k*SLOT_BYTES. Arithmetic is modulo 2^ADDR_W; k*SLOT_BYTES is computed by an accumulator, not a multiplier.
  - fillIdx and k increment; fillIdx wraps mod 32.
  - On the write with k == n-1: wrPtr <= fillIdx+1 (mod 32), lastNum <= fillIdx, rgstrAck pulses on the following cycle, return to IDLE.
  - A registration of n slots therefore occupies n FILL cycles. rgstrPtr stays at its old value until completion.
  - bufRegister is ignored during FILL; no queueing.
- Release (any state), bufRelease = 1:
  - m = min(releaseNum, used).
  - rdPtr += m (mod 32), used -= m.
  - If releaseNum > used, pulse releaseErr.
  - releaseNum == 0 is a no-op with no error.
- Simultaneous registration accept and release in the same cycle:
  - used_next = used + n - m.
  - Acceptance is checked against used before release (conservative).
  - The release clamp uses used before reservation, so reserved-but-unfilled slots cannot be released.
- Status outputs are registered from used_next: poolEmpty, poolFull, freeCount all update the cycle after the event.
- Wrap-around: pointer arithmetic is 5-bit natural overflow. used is 6-bit and saturation-free, since reservation is bounded by freeCount.
- Table read: slotRdData <= table[slotRdAddr] every cycle.
  - A read of the slot being written in the same cycle returns the old value (read-before-write).
- Reset asserted mid-FILL: returns to IDLE, partial registration discarded, all counters zero, no rgstrAck.

Decomposition:
- Shared package ddp_pkg:
  - DDP_POOL_DEPTH = 32, DDP_PTR_W = 5, DDP_SLOT_BYTES.
  - Pool state enum {IDLE, FILL}.
- One sub-module: ddp_slot_ram, a DEPTH x ADDR_W single-write, single-registered-read RAM.
- Pointer, count and FSM logic stay in ddp_buf_pool.

Test Plan:
- Reset, then bufRegister with rgstrNum=3, rgstrAddr=0x1000:
  - rgstrBusy is high for 3 cycles, then rgstrAck pulses.
  - Table[0..2] = 0x1000, 0x2000, 0x3000.
  - rgstrPtr=3, lastNum=2, freeCount=29, poolEmpty=0.
- Fill the pool with registrations of 7,7,7,7,4 slots:
  - poolFull=1, freeCount=0, rgstrPtr wraps to 0.
  - A further rgstrNum=1 request gives rgstrReject and no state change.
- With wrPtr=30 and 32 slots free, register 4 slots:
  - Writes land at slots 30, 31, 0, 1.
  - lastNum=1, rgstrPtr=2.
- With used=5, bufRelease releaseNum=7:
  - used=0, rdPtr advances by 5, releaseErr pulses, poolEmpty=1.
- With used=30, bufRegister rgstrNum=2 and bufRelease releaseNum=2 in the same cycle:
  - Registration is accepted (2 <= 2 free).
  - used_next=30, poolFull stays 0.
- Assert reset two cycles into a 5-slot FILL:
  - No rgstrAck; wrPtr=0, freeCount=32, state IDLE.
  - A new rgstrNum=1 request is accepted normally.
